// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module : muldiv_pkg
// Brief  : Shared constants for the RV32M multiply/divide unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam int DEF_XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/muldiv_datapath.sv
// ============================================================================
// Module : muldiv_datapath
// Brief  : Shift-add multiply / restoring divide iteration engine.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   op_a_i,
  input  logic [XLEN-1:0]   op_b_i,
  output logic [2*XLEN-1:0] acc_next_o,
  output logic              last_o
);

  localparam int CW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   trial;
  logic              trial_unused_bit;

  // Divide: acc = {remainder, dividend/quotient}; top 33 bits are the shifted remainder.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    trial   = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opnd_q};
    if (is_div_i) begin
      if (!trial[XLEN+1]) acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                acc_d = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  assign trial_unused_bit = trial[XLEN];
  assign acc_next_o       = acc_d;
  assign last_o           = (cnt_q == CW'(XLEN-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      acc_q  <= {{XLEN{1'b0}}, op_a_i};
      opnd_q <= op_b_i;
      cnt_q  <= '0;
    end else if (step_i) begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module : muldiv_unit
// Brief  : Iterative RV32M multiply/divide unit with FSM, special cases, sign fix.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            rd_write
);

  logic [1:0]        state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic              spec_q, spec_d;
  logic [XLEN-1:0]   spec_val_q, spec_val_d;
  logic [4:0]        rd_pend_q, rd_pend_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              load, step, last;
  logic [2*XLEN-1:0] acc_next, prod;
  logic [XLEN-1:0]   abs_a, abs_b, fixed, special_val;
  logic              sign_a, sign_b, sgn_a_op, sgn_b_op, neg_in, special;
  logic              div_zero, div_ovf;

  muldiv_datapath #(.XLEN(XLEN)) u_dp (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .step_i     (step),
    .is_div_i   (f3_q[2]),
    .op_a_i     (abs_a),
    .op_b_i     (abs_b),
    .acc_next_o (acc_next),
    .last_o     (last)
  );

  always_comb begin
    sign_a   = rs1_data[XLEN-1];
    sign_b   = rs2_data[XLEN-1];
    sgn_a_op = funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    sgn_b_op = funct3 inside {F3_MULH, F3_DIV, F3_REM};
    abs_a    = (sgn_a_op && sign_a) ? -rs1_data : rs1_data;
    abs_b    = (sgn_b_op && sign_b) ? -rs2_data : rs2_data;
    case (funct3)
      F3_MULH, F3_DIV: neg_in = sign_a ^ sign_b;
      F3_MULHSU, F3_REM: neg_in = sign_a;
      default:         neg_in = 1'b0;
    endcase
    div_zero = (rs2_data == '0);
    div_ovf  = (funct3 inside {F3_DIV, F3_REM}) &&
               (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    special  = funct3[2] && (div_zero || div_ovf);
    // Bit 1 of funct3 separates REM/REMU from DIV/DIVU.
    if (div_zero) special_val = funct3[1] ? rs1_data : '1;
    else          special_val = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  always_comb begin
    prod = neg_q ? -acc_next : acc_next;
    case (f3_q)
      F3_MUL:                      fixed = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fixed = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             fixed = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
      default:                     fixed = neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    endcase
  end

  // Special cases spend one CALC cycle so done lands one edge after the start edge.
  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    rd_pend_d  = rd_pend_q;
    rd_out_d   = rd_out_q;
    result_d   = result_q;
    load       = 1'b0;
    step       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          f3_d       = funct3;
          neg_d      = neg_in;
          rd_pend_d  = rd_in;
          spec_d     = special;
          spec_val_d = special_val;
          load       = !special;
          state_d    = ST_CALC;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (spec_q) begin
          result_d = spec_val_q;
          rd_out_d = rd_pend_q;
          state_d  = ST_DONE;
        end else begin
          step = 1'b1;
          if (last) begin
            result_d = fixed;
            rd_out_d = rd_pend_q;
            state_d  = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      f3_q       <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      rd_pend_q  <= '0;
      rd_out_q   <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      f3_q       <= f3_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      rd_pend_q  <= rd_pend_d;
      rd_out_q   <= rd_out_d;
      result_q   <= result_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign rd_out   = rd_out_q;
  assign rd_write = done && (rd_out_q != '0);

endmodule

`default_nettype wire
